// File: rtl/jb_imu.sv
// SPI mode-0 master that reads a 19-byte IMU frame (command + 18 data bytes) per start pulse.
// The nine 16-bit words are published atomically with a one-cycle done pulse; start is ignored while busy.
module jb_imu #(
  parameter int unsigned CLK_DIV = 8,
  parameter logic [7:0]  CMD     = 8'h01,
  parameter int unsigned GAP     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        miso,
  output logic        mosi,
  output logic        sck,
  output logic        ss,
  output logic [15:0] roll,
  output logic [15:0] pitch,
  output logic [15:0] yaw,
  output logic [15:0] roll_rate,
  output logic [15:0] pitch_rate,
  output logic [15:0] yaw_rate,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SHIFT, S_GAP, S_DESELECT, S_DONE
  } state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);
  localparam logic [4:0] LAST_BYTE = 5'd18;

  state_t            state_q, state_d;
  logic [7:0]        div_q, div_d;
  logic              phase_q, phase_d;
  logic [2:0]        bit_q, bit_d;
  logic [4:0]        byte_q, byte_d;
  logic [7:0]        gap_q, gap_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        rx_q, rx_d;
  logic [17:0][7:0]  shadow_q, shadow_d;
  logic [8:0][15:0]  out_q, out_d;
  logic              sck_q, sck_d;
  logic              ss_q, ss_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic              div_end;

  assign div_end = (div_q == DIV_LAST);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    gap_d    = gap_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SELECT;
          div_d   = 8'd0;
          phase_d = 1'b0;
          bit_d   = 3'd0;
          byte_d  = 5'd0;
          tx_d    = CMD;
        end
      end
      S_SELECT: begin
        div_d = div_q + 8'd1;
        if (div_end) begin
          div_d   = 8'd0;
          phase_d = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        div_d = div_q + 8'd1;
        if (div_end) begin
          div_d = 8'd0;
          if (!phase_q) begin
            // Falling edge: advance mosi so it settles a full half-period before the next rise.
            phase_d = 1'b1;
            tx_d    = {tx_q[6:0], 1'b0};
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              if (byte_q != 5'd0) begin
                shadow_d[byte_q - 5'd1] = rx_q;
              end
              if (byte_q == LAST_BYTE) begin
                state_d = S_DESELECT;
              end else begin
                byte_d  = byte_q + 5'd1;
                tx_d    = 8'h00;
                gap_d   = 8'd0;
                state_d = (GAP > 0) ? S_GAP : S_SHIFT;
              end
            end
          end
        end
      end
      S_GAP: begin
        div_d = div_q + 8'd1;
        if (div_end) begin
          div_d = 8'd0;
          gap_d = gap_q + 8'd1;
          if (gap_q == GAP_LAST) begin
            state_d = S_SHIFT;
          end
        end
      end
      S_DESELECT: begin
        div_d = div_q + 8'd1;
        if (div_end) begin
          div_d   = 8'd0;
          state_d = S_DONE;
          done_d  = 1'b1;
          for (int k = 0; k < 9; k++) begin
            out_d[k] = {shadow_q[2*k], shadow_q[2*k+1]};
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus pins are decoded from the next state so they leave the flops glitch-free.
    sck_d  = (state_d == S_SHIFT) && !phase_d;
    ss_d   = !((state_d == S_SELECT) || (state_d == S_SHIFT) || (state_d == S_GAP));
    mosi_d = ss_d ? 1'b0 : tx_d[7];
    if (sck_d && !sck_q) begin
      rx_d = {rx_q[6:0], miso};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      div_q    <= 8'd0;
      phase_q  <= 1'b0;
      bit_q    <= 3'd0;
      byte_q   <= 5'd0;
      gap_q    <= 8'd0;
      tx_q     <= 8'd0;
      rx_q     <= 8'd0;
      shadow_q <= '0;
      out_q    <= '0;
      sck_q    <= 1'b0;
      ss_q     <= 1'b1;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      gap_q    <= gap_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      sck_q    <= sck_d;
      ss_q     <= ss_d;
      mosi_q   <= mosi_d;
      done_q   <= done_d;
    end
  end

  assign sck        = sck_q;
  assign ss         = ss_q;
  assign mosi       = mosi_q;
  assign done       = done_q;
  assign roll       = out_q[0];
  assign pitch      = out_q[1];
  assign yaw        = out_q[2];
  assign roll_rate  = out_q[3];
  assign pitch_rate = out_q[4];
  assign yaw_rate   = out_q[5];
  assign accel_x    = out_q[6];
  assign accel_y    = out_q[7];
  assign accel_z    = out_q[8];

endmodule

// File: tb/tb_jb_imu.sv
// Bench for jb_imu: SPI slave serving bytes from a table, bus monitor, and a frame-level word model.
module tb_jb_imu;
  localparam int         CLK_DIV = 8;
  localparam int         GAP     = 2;
  localparam logic [7:0] CMD     = 8'h01;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic miso  = 1'b0;
  logic mosi, sck, ss, done;
  logic [15:0] roll, pitch, yaw, roll_rate, pitch_rate, yaw_rate, accel_x, accel_y, accel_z;
  logic [15:0] obs [9];

  jb_imu #(.CLK_DIV(CLK_DIV), .CMD(CMD), .GAP(GAP)) dut (
    .clock(clock), .reset(reset), .start(start), .miso(miso),
    .mosi(mosi), .sck(sck), .ss(ss),
    .roll(roll), .pitch(pitch), .yaw(yaw),
    .roll_rate(roll_rate), .pitch_rate(pitch_rate), .yaw_rate(yaw_rate),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .done(done)
  );

  always #10 clock = ~clock;

  always_comb begin
    obs[0] = roll;      obs[1] = pitch;      obs[2] = yaw;
    obs[3] = roll_rate; obs[4] = pitch_rate; obs[5] = yaw_rate;
    obs[6] = accel_x;   obs[7] = accel_y;    obs[8] = accel_z;
  end

  // SPI slave: byte stream mem[ptr], ptr advancing after each completed byte, MSB first, shifting on sck fall.
  logic [7:0] mem [256];
  logic [7:0] ptr        = 8'd0;
  logic [7:0] frame_base = 8'd0;
  logic       ss_prev    = 1'b1;
  int         sbit       = 0;

  always @(ss or negedge sck) begin
    logic [7:0] b;
    if (!ss && ss_prev) begin
      sbit       = 0;
      frame_base = ptr;
    end else if (!ss && !sck) begin
      sbit = sbit + 1;
      if (sbit == 8) begin
        sbit = 0;
        ptr  = ptr + 8'd1;
      end
    end
    ss_prev = ss;
    b       = mem[ptr];
    miso    = b[3'(7 - sbit)];
  end

  // Bus monitor sampled just after each rising clock edge; counters are cumulative.
  int cyc = 0, run = 0, edges = 0, idle_tog = 0, hi_bad = 0, lo_bad = 0, last_lead = 0;
  int done_cnt = 0, done_wide = 0, mcnt = 0, mbit = 0, ss_fall_cyc = 0;
  bit seen_edge = 1'b0;
  logic prev_sck = 1'b0, prev_ss = 1'b1, prev_done = 1'b0;
  logic [7:0] mshift = 8'd0;
  logic [7:0] mbytes [1024];

  always @(posedge clock) begin
    #1;
    cyc = cyc + 1;
    if (prev_ss && !ss) begin
      seen_edge   = 1'b0;
      ss_fall_cyc = cyc;
      mbit        = 0;
    end
    if (sck !== prev_sck) begin
      if (ss) idle_tog = idle_tog + 1;
      if (prev_sck && !ss && run != CLK_DIV) hi_bad = hi_bad + 1;
      if (!prev_sck && !ss) begin
        if (seen_edge && run != CLK_DIV && run != CLK_DIV * (1 + GAP)) lo_bad = lo_bad + 1;
        if (!seen_edge) last_lead = cyc - ss_fall_cyc;
        seen_edge = 1'b1;
        edges     = edges + 1;
        mshift    = {mshift[6:0], mosi};
        mbit      = mbit + 1;
        if (mbit == 8) begin
          if (mcnt < 1024) mbytes[mcnt] = mshift;
          mcnt = mcnt + 1;
          mbit = 0;
        end
      end
      run = 1;
    end else begin
      run = run + 1;
    end
    if (done) done_cnt = done_cnt + 1;
    if (done && prev_done) done_wide = done_wide + 1;
    prev_sck  = sck;
    prev_ss   = ss;
    prev_done = done;
  end

  int errors = 0;
  int checks = 0;
  string names [9] = '{"roll", "pitch", "yaw", "roll_rate", "pitch_rate", "yaw_rate",
                       "accel_x", "accel_y", "accel_z"};
  logic [15:0] spec_a [9] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A,
                              16'h0B0C, 16'h0D0E, 16'h0F10, 16'h1112};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected)
    else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clock);
      if (done === 1'b1) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_edges(input int target);
    bit got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clock);
      if (edges >= target) got = 1'b1;
    end
    check("edge_reached", 32'(got), 32'd1);
  endtask

  // Word k of a frame is {byte 2k+1, byte 2k+2} of the bytes the slave served since ss fell.
  task automatic check_model(input string frame);
    for (int k = 0; k < 9; k++) begin
      int hi_i, lo_i;
      hi_i = (int'(frame_base) + 2 * k + 1) % 256;
      lo_i = (int'(frame_base) + 2 * k + 2) % 256;
      check({frame, "_", names[k]}, 32'(obs[k]), 32'({mem[hi_i], mem[lo_i]}));
    end
  endtask

  int e0, m0, d0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    // Reset and idle behaviour.
    reset = 1'b1;
    tick(5);
    check("rst_ss", 32'(ss), 32'd1);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    for (int k = 0; k < 9; k++) check({"rst_", names[k]}, 32'(obs[k]), 32'd0);
    reset = 1'b0;
    e0 = idle_tog;
    tick(60);
    check("idle_no_sck", 32'(idle_tog - e0), 32'd0);
    check("idle_ss", 32'(ss), 32'd1);

    // Frame A then back-to-back frame B with the incrementing slave.
    e0 = edges; m0 = mcnt; d0 = done_cnt;
    pulse_start();
    wait_done();
    for (int k = 0; k < 9; k++) check({"a_", names[k]}, 32'(obs[k]), 32'(spec_a[k]));
    check("a_edges", 32'(edges - e0), 32'd152);
    check("a_mosi_bytes", 32'(mcnt - m0), 32'd19);
    check("a_mosi_cmd", 32'(mbytes[m0]), 32'(CMD));
    for (int i = 1; i < 19; i++) check("a_mosi_zero", 32'(mbytes[m0 + i]), 32'd0);
    check("a_lead", 32'(last_lead >= CLK_DIV), 32'd1);
    tick(1);
    pulse_start();
    wait_done();
    check("b_roll", 32'(roll), 32'h1415);
    check("b_accel_z", 32'(accel_z), 32'h2425);
    check_model("b");
    tick(5);
    check("ab_done_cnt", 32'(done_cnt - d0), 32'd2);
    check("ab_done_width", 32'(done_wide), 32'd0);
    check("ab_sck_high", 32'(hi_bad), 32'd0);
    check("ab_sck_low", 32'(lo_bad), 32'd0);

    // Second start during SHIFT must be dropped.
    e0 = edges; d0 = done_cnt;
    pulse_start();
    wait_edges(e0 + 20);
    pulse_start();
    wait_done();
    check_model("c");
    tick(300);
    check("c_edges", 32'(edges - e0), 32'd152);
    check("c_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Reset during byte 5 aborts the frame and clears the outputs.
    e0 = edges;
    pulse_start();
    wait_edges(e0 + 5 * 8 + 3);
    d0 = done_cnt;
    reset = 1'b1;
    tick(1);
    check("abort_ss", 32'(ss), 32'd1);
    check("abort_sck", 32'(sck), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 9; k++) check({"abort_", names[k]}, 32'(obs[k]), 32'd0);
    tick(200);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_ss_idle", 32'(ss), 32'd1);
    e0 = edges;
    pulse_start();
    wait_done();
    check_model("d");
    check("d_edges", 32'(edges - e0), 32'd152);

    // Random slave data.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int f = 0; f < 2; f++) begin
      tick(1 + $urandom_range(0, 20));
      pulse_start();
      wait_done();
      check_model("rnd");
    end
    tick(5);
    check("end_sck_high", 32'(hi_bad), 32'd0);
    check("end_sck_low", 32'(lo_bad), 32'd0);
    check("end_done_width", 32'(done_wide), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
